// File: rtl/mul_batch_engine.sv
// Streaming lane multiplier: reads 512-bit lines of operand pairs and writes one result line per input line.
// Reads are credit-limited so the result FIFO can never overflow.
module mul_batch_engine #(
  parameter int DATA_LEN       = 32,
  parameter int PIPELINE_STAGE = 2,
  parameter int OUT_DEPTH      = 16
) (
  input  logic         clk2,
  input  logic         reset,
  input  logic         cfg_wr_en,
  input  logic [1:0]   cfg_addr,
  input  logic [63:0]  cfg_data,
  output logic         rd_req_valid,
  output logic [41:0]  rd_req_addr,
  input  logic         rd_req_almfull,
  input  logic         rd_rsp_valid,
  input  logic [511:0] rd_rsp_data,
  output logic         wr_req_valid,
  output logic [41:0]  wr_req_addr,
  output logic [511:0] wr_req_data,
  input  logic         wr_req_almfull,
  output logic         busy,
  output logic         done,
  output logic [31:0]  lines_done
);

  localparam int D     = DATA_LEN;
  localparam int LANES = 256 / DATA_LEN;
  localparam int AW    = $clog2(OUT_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]   state;
  logic [41:0]  in_base, out_base;
  logic [31:0]  n_lines;
  logic         signed_mode, high_sel;
  logic [31:0]  rd_count, wr_count;
  logic [31:0]  live, stale;
  logic [PIPELINE_STAGE-1:0] vpipe;
  logic [255:0] dpipe [PIPELINE_STAGE];
  logic [255:0] fifo_mem [OUT_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, fifo_cnt;

  logic         abort_hit, start_hit, cfg_open;
  logic         issue, pop, push, rsp_live, rsp_drop;
  logic [31:0]  pipe_cnt, in_use;
  logic [255:0] lane_res;
  logic [2*D-1:0] ext_a, ext_b, prod;

  always_comb begin
    lane_res = '0;
    ext_a    = '0;
    ext_b    = '0;
    prod     = '0;
    for (int k = 0; k < LANES; k++) begin
      ext_a = signed_mode ? {{D{rd_rsp_data[2*k*D+D-1]}}, rd_rsp_data[2*k*D +: D]}
                          : {{D{1'b0}}, rd_rsp_data[2*k*D +: D]};
      ext_b = signed_mode ? {{D{rd_rsp_data[2*k*D+2*D-1]}}, rd_rsp_data[2*k*D+D +: D]}
                          : {{D{1'b0}}, rd_rsp_data[2*k*D+D +: D]};
      prod  = ext_a * ext_b;
      lane_res[k*D +: D] = high_sel ? prod[2*D-1:D] : prod[D-1:0];
    end
  end

  // Credits cover every line already committed to a FIFO slot: in flight, in the pipe, or queued.
  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < PIPELINE_STAGE; i++) pipe_cnt = pipe_cnt + 32'(vpipe[i]);
    in_use = live + pipe_cnt + 32'(fifo_cnt);
  end

  assign fifo_cnt  = wr_ptr - rd_ptr;
  assign abort_hit = cfg_wr_en && (cfg_addr == 2'd3) && cfg_data[63];
  assign start_hit = cfg_wr_en && (cfg_addr == 2'd0) && !abort_hit;
  assign cfg_open  = (state == S_IDLE) || (state == S_DONE);
  assign issue     = (state == S_RUN) && !rd_req_almfull && (in_use < 32'(OUT_DEPTH)) && !abort_hit;
  assign pop       = (fifo_cnt != '0) && !wr_req_almfull && !abort_hit;
  assign push      = vpipe[PIPELINE_STAGE-1];
  assign rsp_live  = rd_rsp_valid && (stale == 32'd0);
  assign rsp_drop  = rd_rsp_valid && (stale != 32'd0);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk2) begin
    if (reset) begin
      state        <= S_IDLE;
      in_base      <= '0;
      out_base     <= '0;
      n_lines      <= '0;
      signed_mode  <= 1'b0;
      high_sel     <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
      lines_done   <= '0;
      live         <= '0;
      stale        <= '0;
      vpipe        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      wr_req_valid <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_data  <= '0;
    end else begin
      rd_req_valid <= issue;
      wr_req_valid <= pop;
      if (cfg_wr_en && cfg_open) begin
        case (cfg_addr)
          2'd1: in_base  <= cfg_data[47:6];
          2'd2: out_base <= cfg_data[47:6];
          2'd3: begin
            n_lines     <= cfg_data[31:0];
            signed_mode <= cfg_data[32];
            high_sel    <= cfg_data[33];
          end
          default: ;
        endcase
      end
      // Reads still outstanding at abort become stale and are dropped as they come back.
      if (abort_hit) begin
        state  <= S_IDLE;
        vpipe  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        live   <= '0;
        stale  <= stale - 32'(rsp_drop) + live - 32'(rsp_live);
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start_hit) begin
              state      <= (n_lines == 32'd0) ? S_DONE : S_RUN;
              rd_count   <= '0;
              wr_count   <= '0;
              lines_done <= '0;
            end
          end
          S_RUN:   if (issue && (rd_count + 32'd1 == n_lines)) state <= S_DRAIN;
          S_DRAIN: if (pop && (wr_count + 32'd1 == n_lines)) state <= S_DONE;
          default: state <= S_IDLE;
        endcase
        live  <= live + 32'(issue) - 32'(rsp_live);
        stale <= stale - 32'(rsp_drop);
        vpipe[0] <= rsp_live;
        for (int i = 1; i < PIPELINE_STAGE; i++) vpipe[i] <= vpipe[i-1];
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (issue) begin
          rd_count    <= rd_count + 32'd1;
          rd_req_addr <= in_base + 42'(rd_count);
        end
        if (pop) begin
          rd_ptr      <= rd_ptr + 1'b1;
          wr_count    <= wr_count + 32'd1;
          lines_done  <= lines_done + 32'd1;
          wr_req_addr <= out_base + 42'(wr_count);
          wr_req_data <= {256'b0, fifo_mem[rd_ptr[AW-1:0]]};
        end
      end
    end
  end

  always_ff @(posedge clk2) begin
    dpipe[0] <= lane_res;
    for (int i = 1; i < PIPELINE_STAGE; i++) dpipe[i] <= dpipe[i-1];
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= dpipe[PIPELINE_STAGE-1];
  end

endmodule

// File: tb/tb_mul_batch_engine.sv
// Scoreboard bench for mul_batch_engine: a behavioural memory answers reads, expected lines are
// queued when each response is driven and popped against every write request.
module tb_mul_batch_engine;

  localparam int D     = 16;
  localparam int P     = 2;
  localparam int DEPTH = 16;
  localparam int LANES = 256 / D;

  logic         clk2, reset;
  logic         cfg_wr_en;
  logic [1:0]   cfg_addr;
  logic [63:0]  cfg_data;
  logic         rd_req_valid, rd_req_almfull, rd_rsp_valid;
  logic [41:0]  rd_req_addr;
  logic [511:0] rd_rsp_data;
  logic         wr_req_valid, wr_req_almfull;
  logic [41:0]  wr_req_addr;
  logic [511:0] wr_req_data;
  logic         busy, done;
  logic [31:0]  lines_done;

  mul_batch_engine #(.DATA_LEN(D), .PIPELINE_STAGE(P), .OUT_DEPTH(DEPTH)) dut (
    .clk2(clk2), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_almfull(rd_req_almfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_almfull(wr_req_almfull),
    .busy(busy), .done(done), .lines_done(lines_done)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  typedef struct { logic [41:0] addr; int epoch; int ready; } rd_t;
  typedef struct { logic [41:0] addr; logic [511:0] data; } exp_t;

  rd_t          pend_q[$];
  exp_t         exp_q[$];
  logic [511:0] mem_ovr [logic [41:0]];
  int           check_cnt, pass_cnt, cycle, cur_epoch, rd_pulses, wr_pulses, resp_idx;
  int           rsp_lat = 3;
  bit           rsp_hold, rsp_jitter, cur_sgn, cur_hi;
  logic [41:0]  cur_out;
  logic [511:0] last_wr_data, tmp_line;
  int           rd_snap, wr_snap, n_wait;

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    check_cnt++;
    if (observed === expected) pass_cnt++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic logic [31:0] mix(input logic [41:0] a, input int w);
    logic [31:0] x;
    x = a[31:0] * 32'h9E3779B1 ^ (32'(w) * 32'h85EBCA6B) ^ {22'b0, a[41:32]};
    x = x ^ (x >> 15);
    x = x * 32'h2C1B3C6D;
    return x ^ (x >> 13);
  endfunction

  function automatic logic [511:0] line_of(input logic [41:0] a);
    logic [511:0] l;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = mix(a, w);
    return l;
  endfunction

  // Reference lane math done with native signed/unsigned integer multiplies.
  function automatic logic [511:0] model(input logic [511:0] d, input bit sgn, input bit hi);
    logic [511:0] r;
    logic [15:0]  a, b;
    longint       p;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      a = d[2*k*D +: D];
      b = d[2*k*D+D +: D];
      if (sgn) p = longint'($signed(a)) * longint'($signed(b));
      else     p = longint'(a) * longint'(b);
      r[k*D +: D] = hi ? p[31:16] : p[15:0];
    end
    return r;
  endfunction

  // Memory responder and write monitor, sampling just after each rising edge.
  initial begin
    rd_t  r;
    exp_t e;
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    forever begin
      @(posedge clk2);
      #1;
      cycle++;
      if (rd_req_valid === 1'b1) begin
        rd_pulses++;
        checkOutput("rd_almfull", rd_req_almfull, 0);
        pend_q.push_back('{addr: rd_req_addr, epoch: cur_epoch, ready: cycle + rsp_lat});
      end
      if (wr_req_valid === 1'b1) begin
        wr_pulses++;
        last_wr_data = wr_req_data;
        checkOutput("wr_almfull", wr_req_almfull, 0);
        if (exp_q.size() == 0) checkOutput("wr_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("wr_addr", wr_req_addr, e.addr);
          checkOutput("wr_data", wr_req_data, e.data);
        end
      end
      rd_rsp_valid = 1'b0;
      if (!rsp_hold && pend_q.size() > 0 && pend_q[0].ready <= cycle &&
          (!rsp_jitter || $urandom_range(0, 2) != 0)) begin
        r = pend_q.pop_front();
        rd_rsp_data  = line_of(r.addr);
        rd_rsp_valid = 1'b1;
        if (r.epoch == cur_epoch) begin
          exp_q.push_back('{addr: cur_out + 42'(resp_idx), data: model(rd_rsp_data, cur_sgn, cur_hi)});
          resp_idx++;
        end
      end
    end
  end

  task automatic csr_write(input logic [1:0] a, input logic [63:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    @(negedge clk2);
    cfg_wr_en = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
  endtask

  task automatic applyStimulus(input logic [47:0] in_b, input logic [47:0] out_b, input int n,
                               input bit sgn, input bit hi);
    cur_sgn  = sgn;
    cur_hi   = hi;
    cur_out  = out_b[47:6];
    resp_idx = 0;
    csr_write(2'd1, {16'hDEAD, in_b});
    csr_write(2'd2, {16'hBEEF, out_b});
    csr_write(2'd3, {30'b0, hi, sgn, 32'(n)});
    csr_write(2'd0, 64'd0);
  endtask

  task automatic wait_done(input string tag, input int max_cyc, input bit jitter);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      if (jitter) begin
        rd_req_almfull = ($urandom_range(0, 3) == 0);
        wr_req_almfull = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk2);
      n++;
    end
    rd_req_almfull = 1'b0;
    wr_req_almfull = 1'b0;
    if (done !== 1'b1) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  task automatic finish_job(input string tag, input int n, input int wr_before);
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_lines_done"}, lines_done, n);
    checkOutput({tag, "_writes"}, wr_pulses - wr_before, n);
    checkOutput({tag, "_sb_left"}, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0;
    rd_req_almfull = 1'b0; wr_req_almfull = 1'b0;
    repeat (3) @(negedge clk2);
    reset = 1'b0;
    @(negedge clk2);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_lines_done", lines_done, 0);
    checkOutput("rst_rd_valid", rd_req_valid, 0);
    checkOutput("rst_wr_valid", wr_req_valid, 0);

    // Single line, unsigned low half: 7 * 6.
    tmp_line = line_of(42'h100);
    tmp_line[31:0] = {16'd6, 16'd7};
    mem_ovr[42'h100] = tmp_line;
    wr_snap = wr_pulses;
    applyStimulus(48'h0000_0000_4000 | 48'h3F, 48'h0000_0008_0000, 1, 1'b0, 1'b0);
    wait_done("t1", 100, 1'b0);
    finish_job("t1", 1, wr_snap);
    checkOutput("t1_lane0", last_wr_data[15:0], 16'd42);
    checkOutput("t1_upper_zero", last_wr_data[511:256], 0);

    // Signed -1 * 3, both halves.
    tmp_line = line_of(42'h200);
    tmp_line[31:0] = {16'h0003, 16'hFFFF};
    mem_ovr[42'h200] = tmp_line;
    wr_snap = wr_pulses;
    applyStimulus(48'h0000_0000_8000, 48'h0000_0009_0000, 1, 1'b1, 1'b1);
    wait_done("t2", 100, 1'b0);
    finish_job("t2", 1, wr_snap);
    checkOutput("t2_lane0_hi", last_wr_data[15:0], 16'hFFFF);
    wr_snap = wr_pulses;
    applyStimulus(48'h0000_0000_8000, 48'h0000_0009_0000, 1, 1'b1, 1'b0);
    wait_done("t3", 100, 1'b0);
    finish_job("t3", 1, wr_snap);
    checkOutput("t3_lane0_lo", last_wr_data[15:0], 16'hFFFD);

    // Random lines under back-pressure; config writes during the run must be ignored.
    rsp_jitter = 1'b1;
    wr_snap = wr_pulses;
    applyStimulus(48'h0000_1234_0000, 48'h0000_5678_0000, 20, 1'b0, 1'b1);
    checkOutput("t4_busy", busy, 1);
    csr_write(2'd3, {30'b0, 1'b0, 1'b1, 32'd5});
    csr_write(2'd1, 48'h0000_7777_0000);
    wait_done("t4", 2000, 1'b1);
    finish_job("t4", 20, wr_snap);
    wr_snap = wr_pulses;
    applyStimulus(48'h0001_0000_0040, 48'h0002_0000_0000, 25, 1'b1, 1'b0);
    wait_done("t5", 2000, 1'b1);
    finish_job("t5", 25, wr_snap);
    rsp_jitter = 1'b0;

    // Writes blocked: reads must stop exactly at the credit limit.
    wr_req_almfull = 1'b1;
    rd_snap = rd_pulses;
    wr_snap = wr_pulses;
    applyStimulus(48'h0003_0000_0000, 48'h0004_0000_0000, 64, 1'b0, 1'b0);
    repeat (200) @(negedge clk2);
    checkOutput("t6_reads_stalled", rd_pulses - rd_snap, DEPTH);
    checkOutput("t6_no_writes", wr_pulses - wr_snap, 0);
    checkOutput("t6_busy", busy, 1);
    wr_req_almfull = 1'b0;
    wait_done("t6", 1000, 1'b0);
    finish_job("t6", 64, wr_snap);

    // Abort from DONE, then a zero-length job.
    csr_write(2'd3, 64'h8000_0000_0000_0000);
    checkOutput("t7_abort_done", done, 0);
    checkOutput("t7_abort_busy", busy, 0);
    rd_snap = rd_pulses;
    wr_snap = wr_pulses;
    applyStimulus(48'h0005_0000_0000, 48'h0006_0000_0000, 0, 1'b0, 0);
    checkOutput("t7_n0_done", done, 1);
    repeat (5) @(negedge clk2);
    checkOutput("t7_n0_reads", rd_pulses - rd_snap, 0);
    checkOutput("t7_n0_writes", wr_pulses - wr_snap, 0);
    checkOutput("t7_n0_lines", lines_done, 0);

    // Abort with three reads in flight, restart on new data; stale responses must vanish.
    rsp_hold = 1'b1;
    rd_snap = rd_pulses;
    applyStimulus(48'h0007_0000_0000, 48'h0008_0000_0000, 8, 1'b0, 1'b0);
    n_wait = 0;
    while (rd_pulses - rd_snap < 3 && n_wait < 50) begin
      @(negedge clk2);
      n_wait++;
    end
    cur_epoch++;
    exp_q.delete();
    csr_write(2'd3, 64'h8000_0000_0000_0000);
    checkOutput("t8_inflight", rd_pulses - rd_snap, 3);
    checkOutput("t8_abort_busy", busy, 0);
    wr_snap = wr_pulses;
    applyStimulus(48'h0009_0000_0000, 48'h000A_0000_0000, 2, 1'b1, 1'b1);
    rsp_hold = 1'b0;
    wait_done("t8", 200, 1'b0);
    finish_job("t8", 2, wr_snap);

    // Reset while draining, then a normal job.
    wr_req_almfull = 1'b1;
    rd_snap = rd_pulses;
    applyStimulus(48'h000B_0000_0000, 48'h000C_0000_0000, 4, 1'b0, 1'b1);
    n_wait = 0;
    while (rd_pulses - rd_snap < 4 && n_wait < 50) begin
      @(negedge clk2);
      n_wait++;
    end
    repeat (3) @(negedge clk2);
    checkOutput("t9_drain_busy", busy, 1);
    rsp_hold = 1'b1;
    reset = 1'b1;
    pend_q.delete();
    exp_q.delete();
    cur_epoch++;
    @(negedge clk2);
    reset = 1'b0;
    wr_req_almfull = 1'b0;
    rsp_hold = 1'b0;
    checkOutput("t9_rst_busy", busy, 0);
    checkOutput("t9_rst_done", done, 0);
    checkOutput("t9_rst_lines", lines_done, 0);
    checkOutput("t9_rst_rd_valid", rd_req_valid, 0);
    checkOutput("t9_rst_wr_valid", wr_req_valid, 0);
    checkOutput("t9_rst_wr_addr", wr_req_addr, 0);
    wr_snap = wr_pulses;
    applyStimulus(48'h000D_0000_0000, 48'h000E_0000_0000, 3, 1'b1, 1'b0);
    wait_done("t9", 200, 1'b0);
    finish_job("t9", 3, wr_snap);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, check_cnt);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
